// File: rtl/button_debouncer.sv
// button_debouncer: turns a raw, bouncing push-button level into a clean
// debounced level plus single-cycle press pulses (with optional auto-repeat).
//
// Output handshake: btn_pulse is a one-cycle strobe with no ready/backpressure.
// The consumer runs on the same clk and must count every cycle in which
// btn_pulse is high; a pulse is never held waiting for acceptance.
//
// The FSM state is kept in state_q (type state_e) so checkers and benches can
// observe it by hierarchical reference without widening the port list.
module button_debouncer #(
  parameter int STABLE_CYCLES = 250000,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CNT_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int R_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W = (R_MAX > 1) ? $clog2(R_MAX) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
  // DELAY_LAST is only used when auto-repeat is enabled (REPEAT_DELAY > 0).
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);
  localparam bit                REPEAT_EN   = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  // rep_q: 0 while waiting out the initial repeat delay, 1 once in the periodic phase
  logic              rep_q, rep_d;
  logic              level_q, level_d;
  logic              pulse_q, pulse_d;

  // Two-flop synchronizer input path; only s2 is used downstream.
  always_comb begin
    s1_d = btn_in;
    s2_d = s1_q;
  end

  // All state registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      rep_q   <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      rep_q   <= rep_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // Debounce FSM: next state, counters, debounced level and press/repeat pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    rep_d   = rep_q;
    level_d = level_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          pulse_d = 1'b1;
          rcnt_d  = '0;
          rep_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (REPEAT_EN) begin
          if (!rep_q) begin
            // first repeat lands REPEAT_DELAY cycles after entering PRESSED
            if (rcnt_q == DELAY_LAST) begin
              pulse_d = 1'b1;
              rep_d   = 1'b1;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end else begin
            // later repeats every REPEAT_PERIOD cycles
            if (rcnt_q == PERIOD_LAST) begin
              pulse_d = 1'b1;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end
      end
      RELEASE_WAIT: begin
        if (s2_q) begin
          // release glitch: back to held, repeat delay restarts, no new press pulse
          state_d = PRESSED;
          rcnt_d  = '0;
          rep_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule
